// File: rtl/frame_pkg.sv
// Shared types and default sizes for the frame buffer: write/read FSM states
// and the default frame geometry.
package frame_pkg;

    localparam int FRAME_LEN_DEF = 160;
    localparam int DATA_W_DEF    = 16;

    typedef enum logic {
        SYNC,
        FILL
    } wr_state_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/frame_ram.sv
// Two-bank sample store: one write port, one registered read port (latency 1).
// Address is {bank, idx}; the read register holds its value while rd_en is low.
module frame_ram
    import frame_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2][FRAME_LEN];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: neither the array nor the read register is reset; a reset would stop the
    // array mapping onto block RAM, and the top masks the read data until it is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W]][wr_addr[IDX_W-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr[IDX_W]][rd_addr[IDX_W-1:0]];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buffer.sv
// Ping-pong frame buffer: captures framed samples into two banks and replays each
// complete frame as a valid/ready burst tagged with first/last/index.
module frame_buffer
    import frame_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_frame_start,
    input  logic              in_frame_end,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_index,
    output logic              sync_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              ready_en_q;
    logic              out_valid_q, out_valid_d;
    logic [IDX_W-1:0]  out_index_q, out_index_d;
    logic              sync_err_q, sync_err_d;

    logic              accept;
    logic              ram_we, ram_re;
    logic              set_full, clr_full;
    logic [IDX_W-1:0]  ram_wr_idx, ram_rd_idx;
    logic [DATA_W-1:0] ram_rd_data;

    // Driven from registered flags only, so out_ready never reaches in_ready.
    assign in_ready = ready_en_q && !full_q[wr_bank_q];
    assign accept   = in_valid && in_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        ram_we     = 1'b0;
        ram_wr_idx = wr_cnt_q;
        set_full   = 1'b0;
        sync_err_d = 1'b0;
        if (accept) begin
            case (wr_state_q)
                SYNC: begin
                    if (in_frame_start) begin
                        ram_we     = 1'b1;
                        ram_wr_idx = '0;
                        wr_cnt_d   = IDX_W'(1);
                        wr_state_d = FILL;
                    end
                end
                FILL: begin
                    if (wr_cnt_q == '0 && !in_frame_start) begin
                        sync_err_d = 1'b1;
                        wr_state_d = SYNC;
                    end else if (in_frame_start && wr_cnt_q != '0) begin
                        sync_err_d = 1'b1;
                        ram_we     = 1'b1;
                        ram_wr_idx = '0;
                        wr_cnt_d   = IDX_W'(1);
                    end else if (in_frame_end != (wr_cnt_q == LAST_IDX)) begin
                        // Marker and count disagree: the bank is abandoned unfilled.
                        sync_err_d = 1'b1;
                        wr_cnt_d   = '0;
                        wr_state_d = SYNC;
                    end else if (in_frame_end) begin
                        ram_we    = 1'b1;
                        set_full  = 1'b1;
                        wr_bank_d = !wr_bank_q;
                        wr_cnt_d  = '0;
                    end else begin
                        ram_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
                default: wr_state_d = SYNC;
            endcase
        end
    end

    // The RAM read register is the output stage: it only advances on a handshake.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        ram_re      = 1'b0;
        ram_rd_idx  = out_index_q + 1'b1;
        clr_full    = 1'b0;
        case (rd_state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = PRIME;
                end
            end
            PRIME: begin
                ram_re      = 1'b1;
                ram_rd_idx  = '0;
                out_valid_d = 1'b1;
                out_index_d = '0;
                rd_state_d  = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    if (out_index_q == LAST_IDX) begin
                        clr_full    = 1'b1;
                        rd_bank_d   = !rd_bank_q;
                        out_valid_d = 1'b0;
                        out_index_d = '0;
                        rd_state_d  = IDLE;
                    end else begin
                        ram_re      = 1'b1;
                        out_index_d = out_index_q + 1'b1;
                    end
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (set_full) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q  <= SYNC;
            rd_state_q  <= IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            ready_en_q  <= 1'b1;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            sync_err_q  <= sync_err_d;
        end
    end

    frame_ram #(
        .FRAME_LEN (FRAME_LEN),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr ({wr_bank_q, ram_wr_idx}),
        .wr_data (in_data),
        .rd_en   (ram_re),
        .rd_addr ({rd_bank_q, ram_rd_idx}),
        .rd_data (ram_rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_first = out_valid_q && (out_index_q == '0);
    assign out_last  = out_valid_q && (out_index_q == LAST_IDX);
    assign out_data  = out_valid_q ? ram_rd_data : '0;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with 8-sample frames: latency, bursts, backpressure,
// framing violations and reset in the middle of a burst.
module tb_frame_buffer;

    localparam int FL = 8;
    localparam int DW = 16;
    localparam int IW = 3;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_frame_start;
    logic          in_frame_end;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_first;
    logic          out_last;
    logic [IW-1:0] out_index;
    logic          sync_err;

    int checks   = 0;
    int failures = 0;

    frame_buffer #(
        .FRAME_LEN (FL),
        .DATA_W    (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_frame_start (in_frame_start),
        .in_frame_end   (in_frame_end),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_index      (out_index),
        .sync_err       (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until accepted (bounded wait).
    task automatic push(input logic [DW-1:0] data, input logic s, input logic e);
        int n = 0;
        in_valid       = 1'b1;
        in_data        = data;
        in_frame_start = s;
        in_frame_end   = e;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid       = 1'b0;
        in_frame_start = 1'b0;
        in_frame_end   = 1'b0;
    endtask

    task automatic push_frame(input logic [DW-1:0] base, input int n, input bit mark_end);
        for (int i = 0; i < n; i++) begin
            push(base + DW'(i), (i == 0), mark_end && (i == n - 1));
        end
    endtask

    // Consume n_beats beats of a frame starting at base; every cycle with out_valid
    // is compared, so a value that moves during a stall is caught.
    task automatic drain(input logic [DW-1:0] base, input int n_beats, input bit rnd,
                         output int cycles);
        int beat = 0;
        cycles = 0;
        while (beat < n_beats && cycles < 2000) begin
            out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid) begin
                check("out_data",  32'(out_data),  32'(base) + 32'(beat));
                check("out_index", 32'(out_index), 32'(beat));
                check("out_first", 32'(out_first), 32'(beat == 0));
                check("out_last",  32'(out_last),  32'(beat == FL - 1));
                if (out_ready) beat++;
            end
            tick();
            cycles++;
        end
        check("drain_done", 32'(beat), 32'(n_beats));
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        in_frame_start = 1'b0;
        in_frame_end   = 1'b0;
        out_ready      = 1'b0;
        repeat (2) tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_first", 32'(out_first), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_sync_err",  32'(sync_err),  32'd0);
        reset = 1'b0;
        check("rst_ready_lag", 32'(in_ready), 32'd0);
        tick();
        check("rst_ready_up", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int cyc;

        // Power-on reset
        do_reset();

        // Single frame, out_ready high: latency 2, eight beats back to back
        out_ready = 1'b1;
        push_frame(16'h0100, FL, 1'b1);
        check("lat_e0", 32'(out_valid), 32'd0);
        tick();
        check("lat_e1", 32'(out_valid), 32'd0);
        tick();
        check("lat_e2", 32'(out_valid), 32'd1);
        drain(16'h0100, FL, 1'b0, cyc);
        check("no_bubble", 32'(cyc), 32'(FL));
        check("single_done", 32'(out_valid), 32'd0);
        check("single_sync_err", 32'(sync_err), 32'd0);

        // Backpressure: two frames fill both banks, third stalls
        out_ready = 1'b0;
        push_frame(16'h0200, FL, 1'b1);
        push_frame(16'h0300, FL, 1'b1);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid",  32'(out_valid), 32'd1);
        in_valid       = 1'b1;
        in_data        = 16'h0400;
        in_frame_start = 1'b1;
        in_frame_end   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stall_ready", 32'(in_ready),  32'd0);
            check("bp_stall_data",  32'(out_data),  32'h0200);
            check("bp_stall_first", 32'(out_first), 32'd1);
        end
        drain(16'h0200, FL, 1'b0, cyc);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        fork
            push_frame(16'h0400, FL, 1'b1);
            begin
                int c2;
                drain(16'h0300, FL, 1'b0, c2);
            end
        join
        drain(16'h0400, FL, 1'b0, cyc);

        // Random out_ready over 20 frames of incrementing data
        fork
            begin
                for (int f = 0; f < 20; f++) push_frame(16'h1000 + DW'(f * FL), FL, 1'b1);
            end
            begin
                int c3;
                for (int f = 0; f < 20; f++) drain(16'h1000 + DW'(f * FL), FL, 1'b1, c3);
            end
        join
        out_ready = 1'b1;

        // Early frame_end on the 5th sample
        push_frame(16'h0500, 5, 1'b1);
        check("early_err_pulse", 32'(sync_err), 32'd1);
        tick();
        check("early_err_clear", 32'(sync_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("early_no_emit", 32'(out_valid), 32'd0);
            tick();
        end
        push_frame(16'h0510, FL, 1'b1);
        drain(16'h0510, FL, 1'b0, cyc);
        check("early_recover_err", 32'(sync_err), 32'd0);

        // Startup mid-frame: unmarked samples are dropped without an error
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(16'h0700 + DW'(i), 1'b0, 1'b0);
            check("mid_no_err", 32'(sync_err), 32'd0);
        end
        tick();
        check("mid_no_emit", 32'(out_valid), 32'd0);
        push_frame(16'h0710, FL, 1'b1);
        drain(16'h0710, FL, 1'b0, cyc);

        // Reset while beat 4 of a burst is presented, with a partial frame in the other bank
        out_ready = 1'b0;
        push_frame(16'h0A00, FL, 1'b1);
        push_frame(16'h0900, 3, 1'b0);
        drain(16'h0A00, 4, 1'b0, cyc);
        check("mid_burst_index", 32'(out_index), 32'd4);
        check("mid_burst_data",  32'(out_data),  32'h0A04);
        reset = 1'b1;
        tick();
        check("burst_rst_valid", 32'(out_valid), 32'd0);
        check("burst_rst_ready", 32'(in_ready),  32'd0);
        check("burst_rst_index", 32'(out_index), 32'd0);
        check("burst_rst_data",  32'(out_data),  32'd0);
        reset = 1'b0;
        check("burst_rst_lag", 32'(in_ready), 32'd0);
        tick();
        check("burst_rst_up", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("burst_no_remnant", 32'(out_valid), 32'd0);
            tick();
        end
        push_frame(16'h0B00, FL, 1'b1);
        drain(16'h0B00, FL, 1'b0, cyc);
        check("final_idle", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
